// File: rtl/fir_ser_if.sv
// Sample-side and serial-side signals of the FIR output serializer.
// y_valid is a one-cycle qualifier: there is no ready, so the stage must accept every sample.
interface fir_ser_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   y_in;
    logic          y_valid;
    logic [2:0]    shift;
    logic          clr_flags;
    logic          ser_data;
    logic          ser_clk;
    logic          ser_frame;
    logic [LW-1:0] fifo_level;
    logic          sat_flag;
    logic          ovf_flag;
    logic          busy;
    logic [1:0]    ser_state;

    modport master (
        output y_in, y_valid, shift, clr_flags,
        input  ser_data, ser_clk, ser_frame, fifo_level, sat_flag, ovf_flag, busy, ser_state
    );

    modport slave (
        input  y_in, y_valid, shift, clr_flags,
        output ser_data, ser_clk, ser_frame, fifo_level, sat_flag, ovf_flag, busy, ser_state
    );
endinterface

// File: rtl/fir_output_serializer.sv
// Re-quantizes 16-bit FIR samples to saturated signed 8 bits, buffers them in a FIFO
// and shifts them out MSB-first on a framed serial link.
module fir_output_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input logic      clk,
    input logic      rst_n,
    fir_ser_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      q_q, q_d;
    logic            q_valid_q, q_valid_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic            sat_flag_q, sat_flag_d, ovf_flag_q, ovf_flag_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic signed [16:0] y_ext, bias, sum, s;
    logic               sat_hi, sat_lo, sat_set;
    logic [7:0]         q_calc;
    logic               push, pop, full, push_ok, ovf_set;

    // 17 bits holds 0x7FFF plus the largest bias without wrapping.
    always_comb begin
        y_ext   = {bus.y_in[15], bus.y_in};
        bias    = (bus.shift == 3'd0) ? 17'sd0 : (17'sd1 <<< (bus.shift - 3'd1));
        sum     = y_ext + bias;
        s       = sum >>> bus.shift;
        sat_hi  = (s > 17'sd127);
        sat_lo  = (s < -17'sd128);
        q_calc  = sat_hi ? 8'h7F : (sat_lo ? 8'h80 : s[7:0]);
        sat_set = bus.y_valid && (sat_hi || sat_lo);
        q_d       = bus.y_valid ? q_calc : q_q;
        q_valid_d = bus.y_valid;
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop       = 1'b1;
                    shreg_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = 3'd7;
                    div_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    shreg_d   = {shreg_q[6:0], 1'b0};
                    if (bit_cnt_q == 3'd0) state_d = S_GAP;
                    else                   bit_cnt_d = bit_cnt_q - 3'd1;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A push into a full FIFO still lands when the serializer pops in the same cycle.
    always_comb begin
        push     = q_valid_q;
        full     = (level_q == LVL_FULL);
        push_ok  = push && (!full || pop);
        ovf_set  = push && full && !pop;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop)      level_d = level_q + 1'b1;
        else if (!push_ok && pop) level_d = level_q - 1'b1;

        sat_flag_d = bus.clr_flags ? 1'b0 : sat_flag_q;
        ovf_flag_d = bus.clr_flags ? 1'b0 : ovf_flag_q;
        if (sat_set) sat_flag_d = 1'b1;
        if (ovf_set) ovf_flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            sat_flag_q <= 1'b0;
            ovf_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            sat_flag_q <= sat_flag_d;
            ovf_flag_q <= ovf_flag_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= q_q;
    end

    always_comb begin
        bus.ser_frame  = (state_q == S_SHIFT);
        bus.ser_data   = bus.ser_frame && shreg_q[7];
        bus.ser_clk    = bus.ser_frame && (div_cnt_q >= DIV_HALF);
        bus.fifo_level = level_q;
        bus.sat_flag   = sat_flag_q;
        bus.ovf_flag   = ovf_flag_q;
        bus.busy       = (state_q != S_IDLE) || (level_q != '0);
        bus.ser_state  = state_q;
    end
endmodule

// File: tb/tb_fir_output_serializer.sv
// Directed bench for fir_output_serializer: a frame monitor decodes the serial link and
// the main sequence checks quantization, flags, FIFO behaviour, frame timing and reset.
module tb_fir_output_serializer;
    localparam int FIFO_DEPTH = 4;
    localparam int CLK_DIV    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fir_ser_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    fir_output_serializer #(.FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Frame monitor: samples the link on the falling edge.
    logic [7:0] got_q[$];
    int         len_q[$];
    int         rise_q[$];
    int         bad_rise = 0, bad_idle = 0, last_gap = 0, start_cyc = 0, low_cnt = 0;
    int         len = 0, rises = 0;
    bit         in_frame = 0;
    logic [7:0] cap;
    logic       prev_clk;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 0;
            low_cnt  = 0;
        end else if (bus.ser_frame) begin
            if (!in_frame) begin
                in_frame  = 1;
                len       = 0;
                rises     = 0;
                cap       = 8'h00;
                prev_clk  = 1'b0;
                last_gap  = low_cnt;
                start_cyc = cyc;
            end
            if (len % CLK_DIV == 0) cap = {cap[6:0], bus.ser_data};
            if (bus.ser_clk && !prev_clk) begin
                rises++;
                if (len % CLK_DIV != CLK_DIV / 2) bad_rise++;
            end
            prev_clk = bus.ser_clk;
            len++;
        end else begin
            if (in_frame) begin
                in_frame = 0;
                got_q.push_back(cap);
                len_q.push_back(len);
                rise_q.push_back(rises);
                low_cnt = 0;
            end
            low_cnt++;
            if (bus.ser_data || bus.ser_clk) bad_idle++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] y, input logic [2:0] sh);
        bus.y_in    = y;
        bus.shift   = sh;
        bus.y_valid = 1'b1;
        step();
        bus.y_valid = 1'b0;
    endtask

    task automatic clear_flags();
        bus.clr_flags = 1'b1;
        step();
        bus.clr_flags = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] exp);
        int b = 0;
        while (got_q.size() == 0 && b < 400) begin
            step();
            b++;
        end
        check({tag, "_arrived"}, 32'(got_q.size() != 0), 32'd1);
        if (got_q.size() != 0) begin
            check({tag, "_byte"}, 32'(got_q.pop_front()), 32'(exp));
            check({tag, "_len"}, 32'(len_q.pop_front()), 32'(8 * CLK_DIV));
            check({tag, "_rises"}, 32'(rise_q.pop_front()), 32'd8);
        end
    endtask

    initial begin
        int c0;
        int peak;
        bus.y_in      = '0;
        bus.y_valid   = 1'b0;
        bus.shift     = '0;
        bus.clr_flags = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_frame", 32'(bus.ser_frame), 32'd0);
        check("rst_data", 32'(bus.ser_data), 32'd0);
        check("rst_clk", 32'(bus.ser_clk), 32'd0);
        check("rst_level", 32'(bus.fifo_level), 32'd0);
        check("rst_sat", 32'(bus.sat_flag), 32'd0);
        check("rst_ovf", 32'(bus.ovf_flag), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_state", 32'(bus.ser_state), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Pass-through and latency
        c0 = cyc;
        send(16'h0042, 3'd0);
        check("pt_sat", 32'(bus.sat_flag), 32'd0);
        step();
        check("pt_level_c2", 32'(bus.fifo_level), 32'd1);
        check("pt_frame_c2", 32'(bus.ser_frame), 32'd0);
        expect_frame("pt", 8'h42);
        check("pt_latency", 32'(start_cyc - c0), 32'd3);
        check("pt_busy_end", 32'(bus.busy), 32'd0);

        // Rounding
        send(16'd24, 3'd4);
        expect_frame("rnd24", 8'h02);
        send(16'd23, 3'd4);
        expect_frame("rnd23", 8'h01);
        send(16'hFFE8, 3'd4);
        expect_frame("rndm24", 8'hFF);
        check("rnd_nosat", 32'(bus.sat_flag), 32'd0);
        send(16'h7FFF, 3'd7);
        check("rnd7_sat", 32'(bus.sat_flag), 32'd1);
        expect_frame("rnd7", 8'h7F);
        clear_flags();
        check("rnd7_clr", 32'(bus.sat_flag), 32'd0);

        // Saturation, including set winning over a simultaneous clear
        send(16'h0200, 3'd0);
        check("satp_flag", 32'(bus.sat_flag), 32'd1);
        expect_frame("satp", 8'h7F);
        clear_flags();
        check("satp_clr", 32'(bus.sat_flag), 32'd0);
        bus.clr_flags = 1'b1;
        send(16'hFE00, 3'd0);
        bus.clr_flags = 1'b0;
        check("satn_prio", 32'(bus.sat_flag), 32'd1);
        expect_frame("satn", 8'h80);
        clear_flags();
        check("satn_clr", 32'(bus.sat_flag), 32'd0);

        // Overflow: six back-to-back samples into a four-deep FIFO
        peak = 0;
        for (int i = 1; i <= 6; i++) begin
            bus.y_in    = 16'(i);
            bus.shift   = 3'd0;
            bus.y_valid = 1'b1;
            step();
            if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
        end
        bus.y_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
        end
        check("ovf_flag", 32'(bus.ovf_flag), 32'd1);
        check("ovf_peak", 32'(peak), 32'd4);
        check("ovf_nosat", 32'(bus.sat_flag), 32'd0);
        for (int i = 1; i <= 5; i++) expect_frame($sformatf("ovf_b%0d", i), 8'(i));
        check("ovf_busy_end", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 50; i++) step();
        check("ovf_no6th", 32'(got_q.size()), 32'd0);
        clear_flags();
        check("ovf_clr", 32'(bus.ovf_flag), 32'd0);

        // Back-to-back frames
        bus.y_in    = 16'h005A;
        bus.shift   = 3'd0;
        bus.y_valid = 1'b1;
        step();
        bus.y_in    = 16'h0033;
        step();
        bus.y_valid = 1'b0;
        expect_frame("b2b_a", 8'h5A);
        expect_frame("b2b_b", 8'h33);
        check("b2b_gap", 32'(last_gap), 32'd2);

        // Reset during bit 3 with two entries queued
        bus.y_valid = 1'b1;
        bus.y_in    = 16'h0011;
        step();
        bus.y_in    = 16'h0022;
        step();
        bus.y_in    = 16'h0033;
        step();
        bus.y_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.ser_frame; i++) step();
        for (int i = 0; i < 3 * CLK_DIV + 1; i++) step();
        check("mid_frame", 32'(bus.ser_frame), 32'd1);
        check("mid_level", 32'(bus.fifo_level), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_frame", 32'(bus.ser_frame), 32'd0);
        check("mid_rst_data", 32'(bus.ser_data), 32'd0);
        check("mid_rst_clk", 32'(bus.ser_clk), 32'd0);
        check("mid_rst_level", 32'(bus.fifo_level), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) step();
        check("mid_no_residual", 32'(got_q.size()), 32'd0);
        check("mid_idle_busy", 32'(bus.busy), 32'd0);
        send(16'h0024, 3'd0);
        expect_frame("post_rst", 8'h24);

        check("clk_mid_bit", 32'(bad_rise), 32'd0);
        check("idle_quiet", 32'(bad_idle), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fir_output_serializer.md
# fir_output_serializer

Output stage placed directly downstream of the FIR core's 16-bit output register. It re-quantizes each filtered sample to signed 8 bits with a programmable right shift, round-half-up and saturation. Results are buffered in a small FIFO and shifted out MSB-first on a framed serial link (data, clock, frame). Sticky status flags report saturation and FIFO overflow.

## Interface

- FIFO_DEPTH, 4: FIFO entries; power of two, ≥2
- CLK_DIV, 4: clk cycles per serial bit; even, ≥2
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- y_in  in  16  filtered sample, two's complement
- y_valid  in  1  y_in qualifier, one sample per high cycle
- shift  in  3  right-shift amount 0..7, sampled with y_valid
- clr_flags  in  1  synchronous clear of sat_flag and ovf_flag
- ser_data  out  1  serial bit, MSB first
- ser_clk  out  1  bit clock; low first half, high second half of each bit
- ser_frame  out  1  high for the 8 bit periods of one byte
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- sat_flag  out  1  sticky: a sample saturated
- ovf_flag  out  1  sticky: a sample was dropped, FIFO full
- busy  out  1  serializer not IDLE, or FIFO non-empty

## Operation

- Quantizer (1 register stage), on y_valid:
  - bias = shift==0 ? 0 : 1<<(shift-1).
  - s = (sext17(y_in) + bias) >>> shift, 17-bit signed, arithmetic shift.
  - q = s>127 ? 0x7F : s<-128 ? 0x80 : s[7:0]; a clamp sets sat_flag.
  - q and q_valid are registered.
- FIFO:
  - Push on q_valid. Pop on serializer load. Circular pointers wrap at FIFO_DEPTH.
  - Push while full with no same-cycle pop: sample dropped, contents unchanged, ovf_flag set.
  - Push and pop in the same cycle while full: both take effect, level unchanged, no overflow.
  - Pop never occurs while empty.
- Flags:
  - Set has priority over clr_flags in the same cycle.
  - Both flags are otherwise held until clr_flags.
- Serializer FSM:
  - IDLE: if FIFO non-empty, pop, load shreg, bit_cnt=7, div_cnt=0, then go to SHIFT. Otherwise stay in IDLE.
  - SHIFT:
    - ser_frame=1, ser_data=shreg[7].
    - ser_clk = (div_cnt ≥ CLK_DIV/2).
    - When div_cnt reaches CLK_DIV-1: div_cnt=0 and shreg<<=1. If bit_cnt==0, go to GAP; otherwise bit_cnt--.
  - GAP: one cycle with frame, data and clk all 0, then go to IDLE.
  - Outside SHIFT, ser_data, ser_clk and ser_frame are 0.

## Timing

- Reset state (asynchronous, immediate):
  - ser_data, ser_clk, ser_frame, sat_flag, ovf_flag, busy all 0.
  - fifo_level 0, FSM in IDLE, quantizer register cleared.
  - Reset mid-frame aborts the byte and flushes the FIFO.
- Latency, with y_valid at cycle 0:
  - q written to FIFO at the cycle-1 edge.
  - fifo_level increments visibly at cycle 2.
  - If the serializer is idle, it pops at cycle 2.
  - ser_frame rises and the MSB appears at cycle 3.
- ser_frame is high for exactly 8×CLK_DIV cycles.
- Back-to-back bytes have 2 frame-low cycles between them (GAP, then IDLE/load). Sustained rate is one byte per 8×CLK_DIV+2 cycles.
- sat_flag is visible the cycle after y_valid. ovf_flag is visible the cycle after the dropped push.
- shift changes take effect only for the sample presented with them.

## Test plan

- Pass-through: shift=0, y_in=0x0042 → byte 0x42. ser_data per bit period 0,1,0,0,0,0,1,0. Frame lasts 32 cycles (CLK_DIV=4) and starts 3 cycles after y_valid.
- Rounding: shift=4.
  - y_in=24 → 0x02.
  - y_in=23 → 0x01.
  - y_in=0xFFE8 (−24) → 0xFF.
  - shift=7, y_in=0x7FFF → 0x7F with sat_flag=1; no 17-bit wrap.
- Saturation: shift=0.
  - y_in=0x0200 → 0x7F.
  - y_in=0xFE00 → 0x80.
  - sat_flag=1 after each. clr_flags returns it to 0.
- Overflow: 6 consecutive y_valid (values 1..6, shift=0, FIFO_DEPTH=4).
  - Sample 6 is dropped and ovf_flag=1.
  - fifo_level peaks at 4.
  - Bytes 1..5 appear in order. busy falls after the last GAP.
- Back-to-back: 2 queued bytes → exactly 2 frame-low cycles between frames. ser_clk shows 8 rising edges per frame, each mid-bit.
- Reset mid-frame: assert rst_n low during bit 3 with 2 entries queued.
  - All outputs go to 0 immediately; fifo_level=0.
  - After release, no residual frame is sent.
  - A new sample serializes normally.
